// File: rtl/mcu_sequencer.sv
// mcu_sequencer: tags decoded 8x8 blocks Y,Y,Y,Y,Cb,Cr into the 4:2:0 channel
// buffer, stalls upstream while the buffer emits its assembled blocks, and
// counts MCUs until the frame is complete.
// Optional build macro: MCU_SEQ_ABORT_EN adds an `abort` input that ends a
// frame early without a done pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// LOAD_Y  | accepting the four Y blocks of the current MCU
// LOAD_CB | accepting the Cb block
// LOAD_CR | accepting the Cr block
// DRAIN   | buffer reading out, upstream stalled for four cycles
// DONE    | one-cycle frame-complete pulse
module mcu_sequencer #(
    parameter int MCU_W = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MCU_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [MCU_W-1:0] num_mcus,
    input  logic             blk_valid,
    output logic             blk_ready,
    output logic             wr_en,
    output logic [1:0]       ch,
    output logic             drain,
    output logic             busy,
    output logic [MCU_W-1:0] mcu_idx,
    output logic             done
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_Y  = 3'd1,
        LOAD_CB = 3'd2,
        LOAD_CR = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state, state_n;
    logic [1:0]       ycnt, ycnt_n;
    logic [2:0]       dcnt, dcnt_n;
    logic [MCU_W-1:0] num_lat, num_lat_n;
    logic [MCU_W-1:0] mcu_idx_n;
    logic             abort_now;

`ifdef MCU_SEQ_ABORT_EN
    assign abort_now = abort && (state != IDLE);
`else
    assign abort_now = 1'b0;
`endif

    // State and counter registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ycnt    <= 2'd0;
            dcnt    <= 3'd0;
            num_lat <= '0;
            mcu_idx <= '0;
        end else begin
            state   <= state_n;
            ycnt    <= ycnt_n;
            dcnt    <= dcnt_n;
            num_lat <= num_lat_n;
            mcu_idx <= mcu_idx_n;
        end
    end

    // Output decode, zero-latency accept strobe, and next-state logic.
    always_comb begin
        state_n   = state;
        ycnt_n    = ycnt;
        dcnt_n    = dcnt;
        num_lat_n = num_lat;
        mcu_idx_n = mcu_idx;
        blk_ready = 1'b0;
        ch        = 2'd0;
        drain     = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;

        case (state)
            LOAD_Y:  begin blk_ready = 1'b1; ch = 2'd0; end
            LOAD_CB: begin blk_ready = 1'b1; ch = 2'd1; end
            LOAD_CR: begin blk_ready = 1'b1; ch = 2'd2; end
            DRAIN:   drain = 1'b1;
            DONE:    done  = 1'b1;
            default: ;
        endcase

        // An abort cycle must not write a block the frame will never use.
        if (abort_now) blk_ready = 1'b0;
        wr_en = blk_valid & blk_ready;

        case (state)
            IDLE: begin
                if (start) begin
                    if (num_mcus != '0) begin
                        num_lat_n = num_mcus;
                        mcu_idx_n = '0;
                        ycnt_n    = 2'd0;
                        state_n   = LOAD_Y;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            LOAD_Y: begin
                if (wr_en) begin
                    ycnt_n = ycnt + 2'd1;
                    if (ycnt == 2'd3) state_n = LOAD_CB;
                end
            end
            LOAD_CB: if (wr_en) state_n = LOAD_CR;
            LOAD_CR: begin
                if (wr_en) begin
                    dcnt_n  = 3'd4;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                dcnt_n = dcnt - 3'd1;
                if (dcnt == 3'd1) begin
                    if (mcu_idx == num_lat - MCU_W'(1)) begin
                        state_n = DONE;
                    end else begin
                        mcu_idx_n = mcu_idx + MCU_W'(1);
                        state_n   = LOAD_Y;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Abort leaves mcu_idx where it was so software can see how far it got.
        if (abort_now) begin
            state_n   = IDLE;
            mcu_idx_n = mcu_idx;
        end
    end
endmodule

// File: doc/mcu_sequencer.md
# mcu_sequencer

Controls the 4:2:0 channel buffer in the decompression datapath. It accepts decoded 8x8 blocks from the IDCT/dequant stage with a valid/ready handshake. For each MCU it tags the blocks in the fixed order Y,Y,Y,Y,Cb,Cr and drives the buffer's `wr_en`/`ch` inputs. While the buffer emits its four assembled output blocks, it stalls upstream, then counts MCUs until the frame is complete.

## Interface
- `MCU_W`, default 16: width of the MCU count and index.
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins a frame. Sampled only in IDLE.
- `num_mcus`  in  MCU_W: MCUs in the frame, latched when `start` is accepted.
- `blk_valid`  in  1: upstream block present on the shared block bus.
- `blk_ready`  out  1: sequencer can accept a block this cycle.
- `wr_en`  out  1: write strobe to the channel buffer, equal to `blk_valid & blk_ready`.
- `ch`  out  2: channel tag to the buffer. 0=Y, 1=Cb, 2=Cr. Value 3 is never driven.
- `drain`  out  1: high during the four cycles the buffer drives `valid_out`.
- `busy`  out  1: high in every state except IDLE.
- `mcu_idx`  out  MCU_W: index of the MCU currently being loaded or drained.
- `done`  out  1: one-cycle pulse at frame end.

## Operation
- States: IDLE, LOAD_Y, LOAD_CB, LOAD_CR, DRAIN, DONE.
- Reset values:
  - state is IDLE.
  - `blk_ready`, `wr_en`, `drain`, `busy` and `done` are 0.
  - `ch` is 0.
  - `mcu_idx`, the Y counter `ycnt[1:0]` and the drain counter `dcnt[2:0]` are 0.
- IDLE:
  - `start` with `num_mcus`≠0 latches `num_mcus`, clears `mcu_idx` and `ycnt`, and moves to LOAD_Y.
  - `start` with `num_mcus`=0 moves to DONE. No writes are issued.
- LOAD_Y: `blk_ready`=1, `ch`=0. Each accept increments `ycnt`. The accept with `ycnt`=3 moves to LOAD_CB; `ycnt` wraps to 0.
- LOAD_CB: `blk_ready`=1, `ch`=1. An accept moves to LOAD_CR.
- LOAD_CR: `blk_ready`=1, `ch`=2. An accept loads `dcnt`=4 and moves to DRAIN.
- DRAIN:
  - `blk_ready`=0 and `drain`=1. `dcnt` decrements each cycle.
  - Upstream is stalled because a new Y write would overwrite a buffer slot that is still being read.
  - When `dcnt` reaches 1, check the MCU index:
    - If `mcu_idx`=`num_mcus`-1, go to DONE.
    - Otherwise increment `mcu_idx` and go to LOAD_Y.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- In IDLE, DRAIN and DONE, `ch` holds 0. `wr_en` is 0 whenever `blk_ready`=0.
- `blk_valid` low in any LOAD state holds the state with no write. There is no timeout.
- `start` while `busy` is ignored.
- `rst` mid-frame returns to IDLE next edge with all reset values. The channel buffer shares `rst`, so partial MCUs are discarded on both sides.
- `mcu_idx` compares against the latched `num_mcus`; it never wraps within a frame.

## Timing
- `wr_en` and `ch` are combinational from state and `blk_valid`, so zero-cycle accept. All other outputs are registered state decodes.
- If the Cr accept is at cycle t, `drain`=1 in cycles t+1 through t+4, aligned with the buffer's `valid_out`.
- At t+5, either `blk_ready`=1 (next MCU) or `done`=1.
- Minimum MCU period with `blk_valid` held high is 10 cycles: 6 accepts plus 4 drain.
- `start` at cycle s gives `blk_ready`=1 at s+1.

## Configuration
- `MCU_SEQ_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 in any non-IDLE state forces IDLE on the next edge.
  - In that same cycle `blk_ready` and `wr_en` are forced to 0.
  - `done` is not pulsed and `mcu_idx` holds its value until the next `start`.
  - `abort` in IDLE has no effect.
- Undefined: the `abort` port does not exist and only `rst` ends a frame early.

## Test plan
- Single MCU: `start` with `num_mcus`=1, `blk_valid` held high -> `wr_en` on 6 consecutive cycles with `ch`=0,0,0,0,1,2. Then `drain` for 4 cycles, `done` at cycle 11 after `start`, then `busy`=0.
- Three MCUs with `blk_valid` held high -> 3×(6 writes + 4 drain), `mcu_idx` stepping 0,1,2, exactly one `done` pulse, 30 cycles from first accept to `done`.
- Bubbles: `blk_valid` deasserted for 2 cycles after the 2nd Y and during LOAD_CB -> `wr_en` count stays 6 and the `ch` sequence is unchanged. `blk_valid`=1 during DRAIN yields `blk_ready`=0 and no writes.
- `num_mcus`=0 -> `done` at s+1, no `wr_en`. `start` pulsed during LOAD_CB of a 2-MCU frame -> ignored, frame completes normally.
- `rst` asserted during the 2nd drain cycle -> next cycle all outputs at reset values. A fresh `start` then runs a full MCU correctly.
- With `MCU_SEQ_ABORT_EN`: `abort` after the 3rd Y accept -> IDLE next cycle, no `wr_en` in the abort cycle, no `done`. A subsequent `start` with `num_mcus`=1 completes normally.
